cordic_engine_iter: RTL and testbench
=====================================

// Module: cordic_engine_iter
// PURPOSE
//  Iterative, parametrised CORDIC engine. One shift-add micro-rotation per clock.
//  Supports ROTATE mode (rotate vector by angle) and VECTOR mode (magnitude/phase).
//  Quadrant pre-rotation gives full +/-pi coverage. Optional gain compensation.
//  Sits between the twiddle/sample source and the FFT butterfly datapath.
//  Uses valid/ready handshakes on both sides.
// PARAMETERS
//  DATA_W    16  signed width of x/y in/out
//  ANGLE_W   16  binary-angle width; 2^ANGLE_W = 2*pi, so 0x4000 = +pi/2 and 0x8000 = -pi
//  ITERS     12  micro-rotations, legal range 8..16 (elaboration $error outside)
//  GAIN_COMP 1   1: scale the result by K(ITERS); 0: raw result carries CORDIC gain ~1.647
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        input beat present
//  in_ready   out  1        engine can accept a beat
//  in_mode    in   1        0 = ROTATE, 1 = VECTOR; sampled on accept
//  x_in,y_in  in   DATA_W   signed input vector
//  z_in       in   ANGLE_W  signed angle; ignored in VECTOR mode (z starts at 0)
//  out_valid  out  1        result present
//  out_ready  in   1        consumer accepts the result
//  x_out,y_out out DATA_W   signed result vector (saturated)
//  z_out      out  ANGLE_W  residual angle (ROTATE) / phase atan2(y,x) (VECTOR)
// BEHAVIOUR
//  - Reset: state = IDLE, iteration counter = 0, out_valid = 0, x/y/z_out = 0, in_ready = 0 while rst_n is low.
//  - FSM states: IDLE -> PRE -> ITER (ITERS cycles) -> SCALE -> DONE.
//  - IDLE: in_ready = 1. Accept on in_valid & in_ready, then go to PRE.
//  - DONE: out_valid = 1 and outputs are held stable until out_ready. On out_ready, go to IDLE.
//  - in_ready = (state == IDLE) | (state == DONE & out_ready). An accept in DONE goes straight to PRE (no bubble).
//  - Latency from accept edge to out_valid = ITERS + 2 cycles. Throughput is one result per ITERS + 3 cycles.
//  - Internal x/y width is DATA_W + 2 (guard bits for gain and sqrt2). Internal z width is ANGLE_W + 1.
//    Inputs are sign-extended.
//  - PRE, ROTATE mode:
//      z in (+pi/2, +pi):   (x, y, z) <- (-y,  x, z - pi/2)
//      z in [-pi, -pi/2):   (x, y, z) <- ( y, -x, z + pi/2)
//      otherwise: pass through unchanged
//  - PRE, VECTOR mode (only when x < 0):
//      y >= 0:  (y, -x, +pi/2)
//      y <  0:  (-y,  x, -pi/2)
//      otherwise z = 0
//  - ITER i = 0..ITERS-1:
//      d = +1 if (ROTATE ? z >= 0 : y < 0), else -1
//      x <- x - d*(y >>> i)
//      y <- y + d*(x >>> i)   (both use the old x/y values)
//      z <- z - d*ATAN[i]
//  - SCALE:
//      GAIN_COMP = 1: x,y <- (x * K_Q + 2^14) >>> 15, with K_Q = round(2^15 * prod cos(atan 2^-i)).
//      GAIN_COMP = 0: pass through.
//      Then saturate to [-2^(DATA_W-1), 2^(DATA_W-1) - 1]. z wraps modulo 2^ANGLE_W (no saturation).
//  - Result registers load only on the SCALE -> DONE edge.
//  - out_ready while not in DONE: ignored. in_valid while busy: not accepted (no drop, no corruption).
//  - rst_n low mid-operation: the transaction is abandoned and no out_valid is ever produced for it.
// STRUCTURE
//  - Package cordic_pkg holds:
//      - typedef cordic_mode_e {ROTATE, VECTOR}
//      - typedef cordic_state_e {IDLE, PRE, ITER, SCALE, DONE}
//      - constant function atan_lut(i, ANGLE_W), returning round(atan(2^-i)/(2*pi) * 2^ANGLE_W)
//      - K_Q table indexed by ITERS 8..16
//      - HALF_PI(ANGLE_W) constant
//  - Sub-module cordic_atan_lut: combinational LUT, ITERS entries, driven by the iteration index.
//  - The FSM and datapath stay in this module.
// TESTING (DATA_W=16, ANGLE_W=16, ITERS=12, GAIN_COMP=1 unless noted)
//  1. ROTATE x=16384, y=0, z=0x2000 (45 deg)
//     -> x_out ~ y_out ~ 11585 (+/-8); out_valid exactly 14 cycles after accept.
//  2. ROTATE x=16384, y=0, z=0x6000 (135 deg)
//     -> x_out ~ -11585, y_out ~ 11585 (+/-8); confirms pre-rotation.
//  3. VECTOR x=-12000, y=-9000
//     -> x_out ~ 15000 (+/-8), y_out ~ 0 (+/-8), z_out ~ -26056 (+/-16).
//  4. Hold out_ready=0 for 5 cycles in DONE
//     -> outputs stable, in_ready=0.
//     Then out_ready=1 with in_valid=1 -> new beat accepted the same cycle, next result 14 cycles later.
//  5. Pull rst_n low at ITER i=5
//     -> out_valid=0 and outputs 0 immediately.
//     After release, in_ready=1 and case 1 reruns correctly.
//  6. VECTOR x=y=32767
//     -> x_out saturates to 32767; z_out ~ 0x2000 (+/-16).
//     With GAIN_COMP=0 -> x_out=32767 and y_out ~ 0.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC engine.
// Angle LUT, gain constant and quadrant helpers.
package cordic_pkg;

  typedef enum logic {
    ROTATE = 1'b0,
    VECTOR = 1'b1
  } cordic_mode_e;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ITER,
    SCALE,
    DONE
  } cordic_state_e;

  function automatic int half_pi(input int aw);
    return 1 << (aw - 2);
  endfunction

  // round(2^15 * prod cos(atan 2^-i)) for i < iters
  function automatic int k_q(input int iters);
    case (iters)
      8:       return 19899;
      9:       return 19899;
      10:      return 19898;
      11:      return 19898;
      12:      return 19898;
      13:      return 19898;
      14:      return 19898;
      15:      return 19898;
      16:      return 19898;
      default: return 19898;
    endcase
  endfunction

  // atan(2^-i) in a 24-bit full circle, rounded to aw bits
  function automatic int atan_lut(input int i, input int aw);
    int t;
    case (i)
      0:       t = 2097152;
      1:       t = 1238021;
      2:       t = 654136;
      3:       t = 332050;
      4:       t = 166669;
      5:       t = 83416;
      6:       t = 41718;
      7:       t = 20860;
      8:       t = 10430;
      9:       t = 5215;
      10:      t = 2608;
      11:      t = 1304;
      12:      t = 652;
      13:      t = 326;
      14:      t = 163;
      15:      t = 81;
      default: t = 0;
    endcase
    if (aw < 24)
      return (t + (1 << (23 - aw))) >> (24 - aw);
    else if (aw == 24)
      return t;
    else
      return t << (aw - 24);
  endfunction

endpackage

// File: rtl/cordic_engine_iter_if.sv
// Valid/ready bundle between the sample source,
// the CORDIC engine and the butterfly datapath.
interface cordic_engine_iter_if #(
  parameter int DATA_W  = 16,
  parameter int ANGLE_W = 16
);

  logic                      in_valid;
  logic                      in_ready;
  logic                      in_mode;
  logic signed [DATA_W-1:0]  x_in;
  logic signed [DATA_W-1:0]  y_in;
  logic signed [ANGLE_W-1:0] z_in;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [DATA_W-1:0]  x_out;
  logic signed [DATA_W-1:0]  y_out;
  logic signed [ANGLE_W-1:0] z_out;

  modport master (
    output in_valid, in_mode,
    output x_in, y_in, z_in,
    output out_ready,
    input  in_ready, out_valid,
    input  x_out, y_out, z_out
  );

  modport slave (
    input  in_valid, in_mode,
    input  x_in, y_in, z_in,
    input  out_ready,
    output in_ready, out_valid,
    output x_out, y_out, z_out
  );

endinterface

// File: rtl/cordic_atan_lut.sv
// Per-iteration arctangent table, indexed by
// the micro-rotation counter.
module cordic_atan_lut
  import cordic_pkg::*;
#(
  parameter int ANGLE_W = 16,
  parameter int ITERS   = 12
) (
  input  logic [3:0]               idx,
  output logic signed [ANGLE_W:0]  atan
);

  localparam int ZW = ANGLE_W + 1;

  logic signed [ZW-1:0] rom [16];

  for (genvar g = 0; g < 16; g++) begin : g_rom
    if (g < ITERS) begin : g_used
      assign rom[g] = ZW'(atan_lut(g, ANGLE_W));
    end else begin : g_unused
      assign rom[g] = '0;
    end
  end

  assign atan = rom[idx];

endmodule

// File: rtl/cordic_engine_iter.sv
// Iterative CORDIC: one micro-rotation per clock,
// quadrant pre-rotation, optional gain compensation.
module cordic_engine_iter
  import cordic_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ANGLE_W   = 16,
  parameter int ITERS     = 12,
  parameter int GAIN_COMP = 1
) (
  input logic clk,
  input logic rst_n,
  cordic_engine_iter_if.slave bus
);

  localparam int XW = DATA_W + 2;
  localparam int ZW = ANGLE_W + 1;
  localparam int PW = XW + 17;

  localparam logic signed [ZW-1:0] HP =
    ZW'(half_pi(ANGLE_W));
  localparam logic [3:0] LAST = 4'(ITERS - 1);
  localparam logic signed [PW-1:0] SMAX =
    (PW'(1) <<< (DATA_W - 1)) - PW'(1);
  localparam logic signed [PW-1:0] SMIN = ~SMAX;

  if (ITERS < 8 || ITERS > 16) begin : g_iters_chk
    $error("cordic_engine_iter: ITERS outside 8..16");
  end

  cordic_state_e state, state_d;
  cordic_mode_e  mode;

  logic signed [XW-1:0] x, y;
  logic signed [XW-1:0] x_pre, y_pre;
  logic signed [XW-1:0] x_it, y_it;
  logic signed [ZW-1:0] z, z_pre, z_it, at;
  logic signed [PW-1:0] x_w, y_w;
  logic [3:0]           cnt;
  logic                 accept, dpos;

  logic signed [DATA_W-1:0]  xo, yo;
  logic signed [ANGLE_W-1:0] zo;

  assign bus.in_ready = rst_n &
    ((state == IDLE) |
     ((state == DONE) & bus.out_ready));
  assign bus.out_valid = (state == DONE);
  assign accept = bus.in_valid & bus.in_ready;
  assign bus.x_out = xo;
  assign bus.y_out = yo;
  assign bus.z_out = zo;

  cordic_atan_lut #(
    .ANGLE_W(ANGLE_W),
    .ITERS  (ITERS)
  ) u_lut (
    .idx (cnt),
    .atan(at)
  );

  function automatic logic signed [DATA_W-1:0]
    sat(input logic signed [PW-1:0] v);
    if (v > SMAX)
      return SMAX[DATA_W-1:0];
    else if (v < SMIN)
      return SMIN[DATA_W-1:0];
    else
      return v[DATA_W-1:0];
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state: DONE hands straight to PRE on a same-cycle accept
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:  if (accept) state_d = PRE;
      PRE:   state_d = ITER;
      ITER:  if (cnt == LAST) state_d = SCALE;
      SCALE: state_d = DONE;
      DONE: begin
        if (accept)             state_d = PRE;
        else if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Quadrant fold into the convergence range
  always_comb begin
    x_pre = x;
    y_pre = y;
    z_pre = z;
    if (mode == ROTATE) begin
      if (z > HP) begin
        x_pre = -y;
        y_pre = x;
        z_pre = z - HP;
      end else if (z < -HP) begin
        x_pre = y;
        y_pre = -x;
        z_pre = z + HP;
      end
    end else if (x[XW-1]) begin
      if (!y[XW-1]) begin
        x_pre = y;
        y_pre = -x;
        z_pre = HP;
      end else begin
        x_pre = -y;
        y_pre = x;
        z_pre = -HP;
      end
    end
  end

  // One shift-add micro-rotation
  always_comb begin
    dpos = (mode == ROTATE) ? ~z[ZW-1] : y[XW-1];
    if (dpos) begin
      x_it = x - (y >>> cnt);
      y_it = y + (x >>> cnt);
      z_it = z - at;
    end else begin
      x_it = x + (y >>> cnt);
      y_it = y - (x >>> cnt);
      z_it = z + at;
    end
  end

  if (GAIN_COMP != 0) begin : g_gain
    localparam logic signed [PW-1:0] KQ =
      PW'(k_q(ITERS));
    localparam logic signed [PW-1:0] RND = PW'(16384);
    assign x_w = (PW'(x) * KQ + RND) >>> 15;
    assign y_w = (PW'(y) * KQ + RND) >>> 15;
  end else begin : g_raw
    assign x_w = PW'(x);
    assign y_w = PW'(y);
  end

  // Working registers: load, fold, iterate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      z    <= '0;
      cnt  <= '0;
      mode <= ROTATE;
    end else if (accept) begin
      x    <= XW'(bus.x_in);
      y    <= XW'(bus.y_in);
      z    <= bus.in_mode ? '0 : ZW'(bus.z_in);
      cnt  <= '0;
      mode <= cordic_mode_e'(bus.in_mode);
    end else begin
      case (state)
        PRE: begin
          x <= x_pre;
          y <= y_pre;
          z <= z_pre;
        end
        ITER: begin
          x   <= x_it;
          y   <= y_it;
          z   <= z_it;
          cnt <= cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Result registers update only on SCALE -> DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xo <= '0;
      yo <= '0;
      zo <= '0;
    end else if (state == SCALE) begin
      xo <= sat(x_w);
      yo <= sat(y_w);
      zo <= z[ANGLE_W-1:0];
    end
  end

endmodule

// File: tb/tb_cordic_engine_iter.sv
// Bench for cordic_engine_iter: vector table,
// handshake stall, mid-run reset, raw-gain build.
module tb_cordic_engine_iter;
  import cordic_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cordic_engine_iter_if #(
    .DATA_W(16), .ANGLE_W(16)
  ) bus ();
  cordic_engine_iter_if #(
    .DATA_W(16), .ANGLE_W(16)
  ) bus0 ();

  cordic_engine_iter #(
    .DATA_W(16), .ANGLE_W(16),
    .ITERS(12), .GAIN_COMP(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  cordic_engine_iter #(
    .DATA_W(16), .ANGLE_W(16),
    .ITERS(12), .GAIN_COMP(0)
  ) dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0)
  );

  typedef struct {
    logic mode;
    int   x, y, z;
    int   ex, ey, ez;
    int   txy, tz;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
  } exp_t;

  exp_t q[$];
  vec_t tab[12];
  vec_t cur;
  int   nchk = 0;
  int   nerr = 0;
  int   cyc = 0;
  logic ov_seen = 1'b0;

  task automatic chk(string name, int act, int exp,
                     int tol, bit wrap);
    int d;
    logic signed [15:0] w;
    d = act - exp;
    if (wrap) begin
      w = 16'(d);
      d = int'(w);
    end
    if (d < 0) d = -d;
    nchk++;
    if (d > tol) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d +/-%0d",
               name, act, exp, tol);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: push on accept, pop on result handshake
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_n) begin
      ov_seen = 1'b0;
    end else begin
      if (bus.out_valid && !ov_seen) begin
        ov_seen = 1'b1;
        if (q.size() == 0) begin
          nchk++;
          nerr++;
          $display("FAIL spurious_out: got out_valid, want none");
        end else begin
          chk("latency", cyc - q[0].acc, 14, 0, 0);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        ov_seen = 1'b0;
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("x_out", int'(bus.x_out), e.v.ex, e.v.txy, 0);
          chk("y_out", int'(bus.y_out), e.v.ey, e.v.txy, 0);
          chk("z_out", int'(bus.z_out), e.v.ez, e.v.tz, 1);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        e.v = cur;
        e.acc = cyc + 1;
        q.push_back(e);
      end
    end
  end

  task automatic send(input vec_t v, output int waits);
    int n;
    cur = v;
    bus.in_mode  = v.mode;
    bus.x_in     = 16'(v.x);
    bus.y_in     = 16'(v.y);
    bus.z_in     = 16'(v.z);
    bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      nchk++;
      nerr++;
      $display("FAIL accept_timeout: got no in_ready, want accept");
    end
    waits = n;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      nchk++;
      nerr++;
      $display("FAIL drain_timeout: got %0d pending, want 0",
               q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, n;
    logic signed [15:0] hx, hy, hz;

    tab[0]  = '{1'b0, 16384, 0, 16'h2000,
                11585, 11585, 0, 8, 16};
    tab[1]  = '{1'b0, 16384, 0, 16'h6000,
                -11585, 11585, 0, 8, 16};
    tab[2]  = '{1'b1, -12000, -9000, 0,
                15000, 0, -26056, 8, 16};
    tab[3]  = '{1'b1, 32767, 32767, 0,
                32767, 0, 8192, 24, 16};
    tab[4]  = '{1'b0, 10000, 0, 0,
                10000, 0, 0, 12, 16};
    tab[5]  = '{1'b0, 0, 10000, -16384,
                10000, 0, 0, 12, 16};
    tab[6]  = '{1'b0, 10000, 0, -32768,
                -10000, 0, 0, 12, 16};
    tab[7]  = '{1'b1, 20000, 0, 0,
                20000, 0, 0, 12, 16};
    tab[8]  = '{1'b1, 0, -20000, 0,
                20000, 0, -16384, 12, 16};
    tab[9]  = '{1'b1, -20000, 0, 0,
                20000, 0, -32768, 12, 16};
    tab[10] = '{1'b0, 8000, 6000, 16384,
                -6000, 8000, 0, 12, 16};
    tab[11] = '{1'b0, -5000, 12000, 10923,
                -12892, 1670, 0, 12, 16};

    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.x_in      = '0;
    bus.y_in      = '0;
    bus.z_in      = '0;
    bus.out_ready = 1'b0;
    bus0.in_valid  = 1'b0;
    bus0.in_mode   = 1'b0;
    bus0.x_in      = '0;
    bus0.y_in      = '0;
    bus0.z_in      = '0;
    bus0.out_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(bus.in_ready), 0, 0, 0);
    chk("rst_out_valid", int'(bus.out_valid), 0, 0, 0);
    chk("rst_x_out", int'(bus.x_out), 0, 0, 0);
    chk("rst_y_out", int'(bus.y_out), 0, 0, 0);
    chk("rst_z_out", int'(bus.z_out), 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", int'(bus.in_ready), 1, 0, 0);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;

    // table, issued back to back
    for (int i = 0; i < 12; i++) send(tab[i], w);
    wait_idle();

    // stall in DONE, then accept in the same cycle
    bus.out_ready = 1'b0;
    send(tab[1], w);
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stall_out_valid", int'(bus.out_valid), 1, 0, 0);
    hx = bus.x_out;
    hy = bus.y_out;
    hz = bus.z_out;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_x_hold", int'(bus.x_out), int'(hx), 0, 0);
      chk("stall_z_hold", int'(bus.z_out), int'(hz), 0, 0);
      chk("stall_y_hold", int'(bus.y_out), int'(hy), 0, 0);
      chk("stall_in_ready", int'(bus.in_ready), 0, 0, 0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    send(tab[0], w);
    chk("accept_in_done", w, 0, 0, 0);
    wait_idle();

    // reset in the middle of ITER i=5
    send(tab[4], w);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_out_valid", int'(bus.out_valid), 0, 0, 0);
    chk("midrst_x_out", int'(bus.x_out), 0, 0, 0);
    chk("midrst_y_out", int'(bus.y_out), 0, 0, 0);
    chk("midrst_in_ready", int'(bus.in_ready), 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", int'(bus.in_ready), 1, 0, 0);
    @(posedge clk);
    #1;
    send(tab[0], w);
    wait_idle();
    repeat (20) @(posedge clk);
    #1;

    // raw-gain build saturates magnitude
    bus0.in_mode  = 1'b1;
    bus0.x_in     = 16'sd32767;
    bus0.y_in     = 16'sd32767;
    bus0.z_in     = '0;
    bus0.in_valid = 1'b1;
    @(negedge clk);
    chk("raw_in_ready", int'(bus0.in_ready), 1, 0, 0);
    @(posedge clk);
    #1 bus0.in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bus0.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("raw_out_valid", int'(bus0.out_valid), 1, 0, 0);
    chk("raw_x_out", int'(bus0.x_out), 32767, 0, 0);
    chk("raw_y_out", int'(bus0.y_out), 0, 48, 0);
    chk("raw_z_out", int'(bus0.z_out), 8192, 16, 1);
    @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==",
             nchk, nerr);
    $finish;
  end

endmodule
